mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Target side of the core's shared memory interface: services mem_read/mem_write with byte/half/word sizing on the tristate data bus.
// - Holds the program/data RAM and a small MMIO window:
//   - TX byte FIFO with valid/ready drain to a serial transmitter.
//   - 64-bit free-running mtime counter.
// - Sits beside the control unit; all core accesses (fetch, load, store) land here.
// PARAMETERS
// - RAM_WORDS   16384     RAM depth in 32-bit words; RAM occupies byte addr 0 .. 4*RAM_WORDS-1
// - MMIO_BASE   32'h7FF00 base of MMIO window (below core's 0x80000 trap limit)
// - FIFO_DEPTH  8         TX FIFO entries, power of two
// - INIT_FILE   ""        if non-empty, RAM preloaded via $readmemh at elaboration
// PORTS
// - clk        in     1   clock; all state updates on posedge
// - reset      in     1   asynchronous, active-high
// - bus        inout  32  shared data bus; driven only while mem_read, else 'z
// - addr       in     32  byte address, valid while mem_read|mem_write
// - mem_read   in     1   read strobe, combinational response in same cycle
// - mem_write  in     1   write strobe, committed at posedge
// - mem_size   in     4   {sbyte,ubyte,shalf,uhalf}; 4'b0 = word
// - tx_valid   out    1   FIFO non-empty
// - tx_data    out    8   FIFO head byte
// - tx_ready   in     1   consumer accepts head when tx_valid&tx_ready at posedge
// - misalign   out    1   combinational: active access with half addr[0]=1 or word addr[1:0]!=0
// BEHAVIOUR
// - Reset (async, immediate): FIFO empty (tx_valid=0, tx_data=0), mtime=0, overflow=0; RAM contents untouched.
// - bus is released ('z) while reset is asserted regardless of mem_read.
// - mem_read and mem_write both high is illegal: write is ignored, read is serviced.
// - Read path (zero latency, combinational):
//   - RAM: word at addr[31:2]; lane = addr[1:0] (byte) or addr[1] (half).
//   - sbyte/shalf sign-extend; ubyte/uhalf zero-extend; mem_size>1 bit set => treat as word.
//   - Misaligned, or address unmapped (>= 4*RAM_WORDS and outside MMIO window): drive 32'h0.
// - Write path (posedge):
//   - Byte/half stores take bus[7:0]/bus[15:0] into the addressed lane only; other lanes preserved.
//   - Misaligned or unmapped writes are dropped with no state change.
// - MMIO window (word accesses only; sub-word MMIO reads return 0, sub-word MMIO writes dropped):
//   - +0x0 TXDATA  W: push bus[7:0]. R: 0.
//   - +0x4 STATUS  R: {23'b0, overflow, count[$clog2(FIFO_DEPTH):0] zero-extended to 8b}. W: any write clears overflow.
//   - +0x8 MTIMEL  R: mtime[31:0]. W: loads mtime[31:0].
//   - +0xC MTIMEH  R: mtime[63:32]. W: loads mtime[63:32].
//   - Other offsets inside the window read 0; writes to them are ignored.
// - mtime increments by 1 every cycle and wraps at 2^64.
//   - A write to MTIMEL/H replaces that half; no increment that cycle (written value stands).
// - TX FIFO:
//   - Pop on tx_valid&tx_ready.
//   - Push accepted if count<FIFO_DEPTH or a pop occurs in the same cycle.
//   - Push on a full FIFO with no pop: byte dropped, overflow<=1 (sticky).
//   - Push and pop on empty: push only (pop impossible since tx_valid=0).
//   - Count unchanged on simultaneous push+pop.
//   - tx_data held stable while tx_valid&!tx_ready.
// - Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
// STRUCTURE
// - Shared package mem_map_pkg:
//   - MMIO offsets (TXDATA, STATUS, MTIMEL, MTIMEH).
//   - mem_size bit indices (SZ_SBYTE=3, SZ_UBYTE=2, SZ_SHALF=1, SZ_UHALF=0).
//   - Region-decode enum {REG_RAM, REG_MMIO, REG_NONE}.
// - One sub-module: tx_fifo (sync FIFO, params WIDTH=8/DEPTH; push/pop/full/empty/count).
//   - Address decode, lane extract/merge and mtime live in mem_responder.
// TESTING
// - Word write 0xDEADBEEF @0x100, read mem_size=0 -> bus=0xDEADBEEF; write then read @0x104 bytes 0x80 with sbyte -> 0xFFFFFF80, ubyte -> 0x00000080.
// - SH 0x1234 @0x102 over 0xDEADBEEF -> word reads 0x1234BEEF; shalf read @0x102 of 0x8001 -> 0xFFFF8001; misaligned LH @0x101 -> bus=0, misalign=1, RAM unchanged.
// - Push 9 bytes (FIFO_DEPTH=8), tx_ready=0 -> STATUS=0x108 (overflow=1, count=8); drain with tx_ready=1 -> bytes 1..8 in order, tx_valid low after 8th; write STATUS -> overflow=0.
// - Full FIFO, push with tx_ready=1 same cycle -> byte accepted, count stays 8, overflow stays 0.
// - mtime: write MTIMEL=0xFFFFFFFE, MTIMEH=0 -> after 3 cycles MTIMEH reads 1 (carry across halves); assert reset mid-run -> MTIMEL=0 and tx_valid=0 immediately, before next clk edge.
// - Read @0x7FF40 (window, unused) and @RAM top+4 -> 0; mem_read low -> bus 'z; reset high with mem_read -> bus 'z.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared address map, access-size encoding and region decode types for the
// core's memory target.
package mem_map_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_MTIMEL = 32'h8;
    localparam logic [31:0] OFF_MTIMEH = 32'hC;
    localparam logic [31:0] MMIO_SPAN  = 32'h100;

    localparam int SZ_SBYTE = 3;
    localparam int SZ_UBYTE = 2;
    localparam int SZ_SHALF = 1;
    localparam int SZ_UHALF = 0;

    typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;
    typedef enum logic [1:0] {ACC_WORD, ACC_HALF, ACC_BYTE} acc_e;

    // Exactly one size bit selects a sub-word access; zero or several bits mean word.
    function automatic acc_e size_decode(input logic [3:0] sz);
        if (sz == (4'b1 << SZ_SBYTE) || sz == (4'b1 << SZ_UBYTE)) return ACC_BYTE;
        if (sz == (4'b1 << SZ_SHALF) || sz == (4'b1 << SZ_UHALF)) return ACC_HALF;
        return ACC_WORD;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO feeding the serial transmitter; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory target for the core: RAM plus an MMIO window (TX FIFO, status, mtime),
// combinational reads onto the shared tristate bus, writes at posedge.
module mem_responder import mem_map_pkg::*; #(
    parameter int          RAM_WORDS  = 16384,
    parameter logic [31:0] MMIO_BASE  = 32'h7FF00,
    parameter int          FIFO_DEPTH = 8,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] bus,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_size,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        misalign
);

    localparam int          IW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];

    region_e     region;
    acc_e        acc;
    logic [31:0] mmio_off, rword, rdata, wlanes;
    logic [IW-1:0] widx;
    logic [15:0] rhalf;
    logic [7:0]  rbyte;
    logic [3:0]  be;
    logic        wr_ok, ram_we, mmio_we, tx_push, tx_pop;
    logic        fifo_full, fifo_empty, overflow;
    logic [CW-1:0] fifo_count;
    logic [63:0] mtime;

    assign acc      = size_decode(mem_size);
    assign mmio_off = addr - MMIO_BASE;

    always_comb begin
        region = REG_NONE;
        if (addr < RAM_BYTES)                                region = REG_RAM;
        else if (addr >= MMIO_BASE && mmio_off < MMIO_SPAN)  region = REG_MMIO;
    end

    assign misalign = (mem_read | mem_write) &
                      ((acc == ACC_HALF && addr[0]) || (acc == ACC_WORD && addr[1:0] != 2'b00));

    assign widx  = addr[IW+1:2];
    assign rword = ram[widx];
    assign rhalf = addr[1] ? rword[31:16] : rword[15:0];
    assign rbyte = rword[{addr[1:0], 3'b000} +: 8];

    always_comb begin
        rdata = '0;
        if (!misalign) begin
            case (region)
                REG_RAM: begin
                    case (acc)
                        ACC_WORD: rdata = rword;
                        ACC_HALF: rdata = mem_size[SZ_SHALF] ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
                        default:  rdata = mem_size[SZ_SBYTE] ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
                    endcase
                end
                REG_MMIO: begin
                    if (acc == ACC_WORD) begin
                        case (mmio_off)
                            OFF_STATUS: rdata = {23'b0, overflow, 8'(fifo_count)};
                            OFF_MTIMEL: rdata = mtime[31:0];
                            OFF_MTIMEH: rdata = mtime[63:32];
                            default:    rdata = '0;
                        endcase
                    end
                end
                default: rdata = '0;
            endcase
        end
    end

    assign bus = (mem_read && !reset) ? rdata : 'z;

    // A simultaneous read strobe wins: the bus carries our read data, not store data.
    assign wr_ok   = mem_write & ~mem_read & ~misalign;
    assign ram_we  = wr_ok && region == REG_RAM;
    assign mmio_we = wr_ok && region == REG_MMIO && acc == ACC_WORD;

    always_comb begin
        be     = 4'b1111;
        wlanes = bus;
        case (acc)
            ACC_BYTE: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{bus[7:0]}};
            end
            ACC_HALF: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{bus[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][8*i +: 8] <= wlanes[8*i +: 8];
        end
    end

    assign tx_push  = mmio_we && mmio_off == OFF_TXDATA;
    assign tx_valid = ~fifo_empty;
    assign tx_pop   = tx_valid & tx_ready;

    tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (mmio_we && mmio_off == OFF_STATUS) begin
            overflow <= 1'b0;
        end else if (tx_push && fifo_full && !tx_pop) begin
            overflow <= 1'b1;
        end
    end

    // A software write to either half freezes the counter for that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (mmio_we && mmio_off == OFF_MTIMEL) begin
            mtime[31:0] <= bus;
        end else if (mmio_we && mmio_off == OFF_MTIMEH) begin
            mtime[63:32] <= bus;
        end else begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized RAM and
// FIFO traffic checked against a byte-array / queue reference model.
module tb_mem_responder;

    localparam logic [31:0] MMIO      = 32'h7FF00;
    localparam logic [31:0] RAM_BYTES = 32'h10000;
    localparam int          DEPTH     = 8;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] addr = '0, bus_drv = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, bus_oe = 1'b0, tx_ready = 1'b0;
    logic [3:0]  mem_size = '0;
    wire  [31:0] bus;
    logic        tx_valid, misalign;
    logic [7:0]  tx_data;

    assign bus = bus_oe ? bus_drv : 'z;

    mem_responder dut (
        .clk(clk), .reset(reset), .bus(bus), .addr(addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0]  mm [int unsigned];
    logic [7:0]  txq [$];
    logic        ovf_m = 1'b0;
    logic [31:0] rv, ev;
    logic        mis;
    logic [3:0]  sz_tab [7] = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3};

    function automatic int nbytes(input logic [3:0] sz);
        if (sz == 4'b1000 || sz == 4'b0100) return 1;
        if (sz == 4'b0010 || sz == 4'b0001) return 2;
        return 4;
    endfunction

    function automatic logic exp_mis(input logic [31:0] a, input logic [3:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] sz);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        if (exp_mis(a, sz) || a >= RAM_BYTES) return '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm.exists(a + i) ? mm[a + i] : 8'h00;
        if ((sz == 4'b1000 || sz == 4'b0010) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] sz, input logic [31:0] d);
        if (exp_mis(a, sz) || a >= RAM_BYTES) return;
        for (int i = 0; i < nbytes(sz); i++) mm[a + i] = d[8*i +: 8];
    endfunction

    // One bus cycle, entered and left at posedge+1; samples the bus mid-cycle.
    task automatic bus_op(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] sz,
                          input logic [31:0] wd, output logic [31:0] r, output logic m);
        logic pop_now, full_before;
        addr = a; mem_size = sz; mem_read = rd; mem_write = wr; bus_drv = wd; bus_oe = wr & ~rd;
        #4;
        r = bus; m = misalign;
        pop_now     = tx_ready && txq.size() > 0;
        full_before = txq.size() == DEPTH;
        if (pop_now) void'(txq.pop_front());
        if (wr && !rd) begin
            model_write(a, sz, wd);
            if (nbytes(sz) == 4 && a == MMIO) begin
                if (!full_before || pop_now) txq.push_back(wd[7:0]);
                else ovf_m = 1'b1;
            end
            if (nbytes(sz) == 4 && a == MMIO + 4) ovf_m = 1'b0;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; bus_oe = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        bus_op(1, 0, MMIO + 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %h want 0", rv); end
    endtask

    task automatic test_ram_basic;
        bus_op(0, 1, 32'h100, 4'h0, 32'hDEADBEEF, rv, mis);
        bus_op(1, 0, 32'h100, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_100: got %h want deadbeef", rv); end
        n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL lw_100_mis: got %b want 0", mis); end
        bus_op(0, 1, 32'h104, 4'h0, 32'h0, rv, mis);
        bus_op(0, 1, 32'h104, 4'h4, 32'h80, rv, mis);
        bus_op(1, 0, 32'h104, 4'h8, 0, rv, mis);
        n_cmp++; if (rv !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_104: got %h want ffffff80", rv); end
        bus_op(1, 0, 32'h104, 4'h4, 0, rv, mis);
        n_cmp++; if (rv !== 32'h00000080) begin n_bad++; $display("FAIL lbu_104: got %h want 00000080", rv); end
        bus_op(0, 1, 32'h102, 4'h1, 32'h1234, rv, mis);
        bus_op(1, 0, 32'h100, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h1234BEEF) begin n_bad++; $display("FAIL sh_102: got %h want 1234beef", rv); end
        bus_op(0, 1, 32'h102, 4'h1, 32'h8001, rv, mis);
        bus_op(1, 0, 32'h102, 4'h2, 0, rv, mis);
        n_cmp++; if (rv !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_102: got %h want ffff8001", rv); end
        bus_op(1, 0, 32'h102, 4'h1, 0, rv, mis);
        n_cmp++; if (rv !== 32'h00008001) begin n_bad++; $display("FAIL lhu_102: got %h want 00008001", rv); end
        bus_op(1, 0, 32'h101, 4'h2, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0 || mis !== 1'b1) begin n_bad++; $display("FAIL lh_101_mis: got %h/%b want 0/1", rv, mis); end
        bus_op(0, 1, 32'h101, 4'h1, 32'hFFFF, rv, mis);
        bus_op(1, 0, 32'h100, 4'hC, 0, rv, mis);
        n_cmp++; if (rv !== 32'h8001BEEF) begin n_bad++; $display("FAIL sh_101_dropped: got %h want 8001beef", rv); end
    endtask

    task automatic test_random_ram;
        logic [31:0] a;
        logic [3:0]  sz;
        int          op;
        for (int i = 0; i < 16; i++) bus_op(0, 1, 32'h200 + 4*i, 4'h0, $urandom, rv, mis);
        for (int i = 0; i < 200; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? RAM_BYTES + $urandom_range(0, 255) : 32'h200 + $urandom_range(0, 63);
            sz = sz_tab[$urandom_range(0, 6)];
            op = $urandom_range(0, 9);
            ev = model_read(a, sz);
            bus_op(op < 5 || op == 9, op >= 5, a, sz, $urandom, rv, mis);
            n_cmp++; if (mis !== exp_mis(a, sz)) begin n_bad++; $display("FAIL rnd_mis @%h sz%h: got %b want %b", a, sz, mis, exp_mis(a, sz)); end
            if (op < 5 || op == 9) begin
                n_cmp++; if (rv !== ev) begin n_bad++; $display("FAIL rnd_rd @%h sz%h: got %h want %h", a, sz, rv, ev); end
            end
        end
    endtask

    task automatic test_fifo_overflow;
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) bus_op(0, 1, MMIO, 4'h0, i, rv, mis);
        n_cmp++; if (tx_data !== 8'd1) begin n_bad++; $display("FAIL ovf_head_hold: got %h want 01", tx_data); end
        bus_op(1, 0, MMIO + 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h108) begin n_bad++; $display("FAIL ovf_status: got %h want 108", rv); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin n_bad++; $display("FAIL drain_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(i)); end
            bus_op(0, 0, 0, 4'h0, 0, rv, mis);
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        bus_op(0, 1, MMIO + 4, 4'h0, 32'h5, rv, mis);
        bus_op(1, 0, MMIO + 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL ovf_clear: got %h want 0", rv); end
    endtask

    task automatic test_fifo_full_pushpop;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_op(0, 1, MMIO, 4'h0, 32'h10 + i, rv, mis);
        tx_ready = 1'b1;
        bus_op(0, 1, MMIO, 4'h0, 32'h18, rv, mis);
        tx_ready = 1'b0;
        bus_op(1, 0, MMIO + 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h008) begin n_bad++; $display("FAIL full_pushpop_status: got %h want 008", rv); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (tx_data !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL full_pushpop_order_%0d: got %h want %h", i, tx_data, 8'(8'h10 + i)); end
            bus_op(0, 0, 0, 4'h0, 0, rv, mis);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_random_fifo;
        int op;
        for (int i = 0; i < 150; i++) begin
            tx_ready = ($urandom_range(0, 9) < 3);
            n_cmp++; if (tx_valid !== (txq.size() != 0)) begin n_bad++; $display("FAIL rfifo_valid: got %b want %b", tx_valid, txq.size() != 0); end
            if (txq.size() != 0) begin
                n_cmp++; if (tx_data !== txq[0]) begin n_bad++; $display("FAIL rfifo_data: got %h want %h", tx_data, txq[0]); end
            end
            op = $urandom_range(0, 9);
            ev = {23'b0, ovf_m, 8'(txq.size())};
            if (op < 5)       bus_op(0, 1, MMIO, 4'h0, $urandom, rv, mis);
            else if (op == 5) bus_op(0, 1, MMIO + 4, 4'h0, $urandom, rv, mis);
            else if (op < 8) begin
                bus_op(1, 0, MMIO + 4, 4'h0, 0, rv, mis);
                n_cmp++; if (rv !== ev) begin n_bad++; $display("FAIL rfifo_status: got %h want %h", rv, ev); end
            end
            else bus_op(0, 0, 0, 4'h0, 0, rv, mis);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && txq.size() > 0; i++) bus_op(0, 0, 0, 4'h0, 0, rv, mis);
        tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0 || txq.size() != 0) begin n_bad++; $display("FAIL rfifo_drain: got %b want 0", tx_valid); end
        bus_op(0, 1, MMIO + 4, 4'h0, 0, rv, mis);
    endtask

    task automatic test_mtime;
        logic [63:0] base;
        int          n;
        bus_op(0, 1, MMIO + 8, 4'h0, 32'hFFFFFFFE, rv, mis);
        bus_op(0, 1, MMIO + 12, 4'h0, 32'h0, rv, mis);
        bus_op(1, 0, MMIO + 8, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mtime_l0: got %h want fffffffe", rv); end
        bus_op(1, 0, MMIO + 12, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL mtime_h1: got %h want 0", rv); end
        bus_op(1, 0, MMIO + 8, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL mtime_l2: got %h want 0", rv); end
        bus_op(1, 0, MMIO + 12, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h1) begin n_bad++; $display("FAIL mtime_carry: got %h want 1", rv); end
        bus_op(0, 1, MMIO + 8, 4'h0, 32'h100, rv, mis);
        bus_op(0, 1, MMIO + 12, 4'h0, 32'h5, rv, mis);
        bus_op(0, 1, MMIO + 8, 4'h4, 32'hAA, rv, mis);
        bus_op(1, 0, MMIO + 8, 4'h4, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL mtime_subword_rd: got %h want 0", rv); end
        bus_op(1, 0, MMIO + 8, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h102) begin n_bad++; $display("FAIL mtime_subword_wr: got %h want 102", rv); end
        for (int t = 0; t < 4; t++) begin
            base = {32'($urandom), 32'($urandom)};
            if (t == 0) base[31:0] = 32'hFFFFFFFC;
            n = $urandom_range(0, 5);
            bus_op(0, 1, MMIO + 8, 4'h0, base[31:0], rv, mis);
            bus_op(0, 1, MMIO + 12, 4'h0, base[63:32], rv, mis);
            for (int k = 0; k < n; k++) bus_op(0, 0, 0, 4'h0, 0, rv, mis);
            bus_op(1, 0, MMIO + 8, 4'h0, 0, rv, mis);
            n_cmp++; if (rv !== 32'(base + n)) begin n_bad++; $display("FAIL mtime_rnd_l: got %h want %h", rv, 32'(base + n)); end
            bus_op(1, 0, MMIO + 12, 4'h0, 0, rv, mis);
            ev = 32'((base + n + 1) >> 32);
            n_cmp++; if (rv !== ev) begin n_bad++; $display("FAIL mtime_rnd_h: got %h want %h", rv, ev); end
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] pat;
        bus_op(1, 0, MMIO + 32'h40, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL rd_window_unused: got %h want 0", rv); end
        bus_op(1, 0, MMIO, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL rd_txdata: got %h want 0", rv); end
        bus_op(0, 1, RAM_BYTES - 4, 4'h0, 32'hCAFEF00D, rv, mis);
        bus_op(0, 1, RAM_BYTES, 4'h0, 32'h12345678, rv, mis);
        bus_op(1, 0, RAM_BYTES - 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rd_ram_top: got %h want cafef00d", rv); end
        bus_op(1, 0, RAM_BYTES + 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL rd_ram_top_plus4: got %h want 0", rv); end
        pat = ~model_read(32'h100, 4'h0);
        addr = 32'h100; mem_size = 4'h0; bus_drv = pat; bus_oe = 1'b1;
        #2;
        n_cmp++; if (bus !== pat) begin n_bad++; $display("FAIL bus_release_idle: got %h want %h", bus, pat); end
        bus_oe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [31:0] pat;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_op(0, 1, MMIO, 4'h0, 32'hA0 + i, rv, mis);
        bus_op(0, 1, MMIO + 8, 4'h0, 32'h55, rv, mis);
        #2; reset = 1'b1; #1;
        n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_tx: got %b/%h want 0/00", tx_valid, tx_data); end
        pat = ~model_read(32'h100, 4'h0);
        addr = 32'h100; mem_size = 4'h0; mem_read = 1'b1; bus_drv = pat; bus_oe = 1'b1;
        #1;
        n_cmp++; if (bus !== pat) begin n_bad++; $display("FAIL midrst_bus_release: got %h want %h", bus, pat); end
        bus_oe = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        txq.delete(); ovf_m = 1'b0;
        bus_op(1, 0, MMIO + 8, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL midrst_mtimel: got %h want 0", rv); end
        bus_op(1, 0, MMIO + 4, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== 32'h0) begin n_bad++; $display("FAIL midrst_status: got %h want 0", rv); end
        ev = model_read(32'h100, 4'h0);
        bus_op(1, 0, 32'h100, 4'h0, 0, rv, mis);
        n_cmp++; if (rv !== ev) begin n_bad++; $display("FAIL midrst_ram_kept: got %h want %h", rv, ev); end
    endtask

    initial begin
        test_reset;
        test_ram_basic;
        test_random_ram;
        test_fifo_overflow;
        test_fifo_full_pushpop;
        test_random_fifo;
        test_mtime;
        test_unmapped;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within 500000 time units");
        $fatal(1);
    end

endmodule
